// File: rtl/cushion_queue.sv
// cushion_queue
//   DEPTH-entry in-order FIFO between execute and mread. It absorbs execute
//   results while the memory side is busy and forwards GPR/CSR writes from
//   every occupied entry, youngest first, to the register-access stage.
//   Optional feature macro: CUSHION_QUEUE_BYPASS_EN. When it is defined, a
//   result presented to an empty queue is shown at the head in the same cycle.
//
// Ports
//   CLK, RST (async, active-low), FLUSH (sync discard of all entries)
//   MEM_WAIT                      memory side busy, blocks pop only
//   EXEC_VALID / EXEC_READY       producer handshake (READY = not full)
//   EXEC_REG_W_*, EXEC_CSR_W_*    GPR / CSR write fields of the result
//   EXEC_SIDE                     opaque remainder of the result
//   CUSHION_VALID / CUSHION_READY consumer handshake on the head entry
//   CUSHION_*                     head entry fields (zero when not valid)
//   FWD_REG_ADDR -> FWD_REG_HIT / FWD_REG_DATA   GPR forwarding query
//   FWD_CSR_ADDR -> FWD_CSR_HIT / FWD_CSR_DATA   CSR forwarding query
//   COUNT                         occupied entries
module cushion_queue #(
  parameter int DEPTH  = 4,
  parameter int SIDE_W = 182
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       FLUSH,
  input  logic                       MEM_WAIT,
  input  logic                       EXEC_VALID,
  output logic                       EXEC_READY,
  input  logic                       EXEC_REG_W_EN,
  input  logic [4:0]                 EXEC_REG_W_RD,
  input  logic [31:0]                EXEC_REG_W_DATA,
  input  logic                       EXEC_CSR_W_EN,
  input  logic [11:0]                EXEC_CSR_W_ADDR,
  input  logic [31:0]                EXEC_CSR_W_DATA,
  input  logic [SIDE_W-1:0]          EXEC_SIDE,
  output logic                       CUSHION_VALID,
  input  logic                       CUSHION_READY,
  output logic                       CUSHION_REG_W_EN,
  output logic [4:0]                 CUSHION_REG_W_RD,
  output logic [31:0]                CUSHION_REG_W_DATA,
  output logic                       CUSHION_CSR_W_EN,
  output logic [11:0]                CUSHION_CSR_W_ADDR,
  output logic [31:0]                CUSHION_CSR_W_DATA,
  output logic [SIDE_W-1:0]          CUSHION_SIDE,
  input  logic [4:0]                 FWD_REG_ADDR,
  output logic                       FWD_REG_HIT,
  output logic [31:0]                FWD_REG_DATA,
  input  logic [11:0]                FWD_CSR_ADDR,
  output logic                       FWD_CSR_HIT,
  output logic [31:0]                FWD_CSR_DATA,
  output logic [$clog2(DEPTH):0]     COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;

  logic              q_reg_en   [DEPTH];
  logic [4:0]        q_reg_rd   [DEPTH];
  logic [31:0]       q_reg_data [DEPTH];
  logic              q_csr_en   [DEPTH];
  logic [11:0]       q_csr_addr [DEPTH];
  logic [31:0]       q_csr_data [DEPTH];
  logic [SIDE_W-1:0] q_side     [DEPTH];

  logic empty, push, pop, wr, adv;
  logic [AW-1:0] fwd_idx;

  assign empty      = (count == '0);
  assign EXEC_READY = (count != CW'(DEPTH));
  assign COUNT      = count;

  always_comb begin
    CUSHION_VALID      = 1'b0;
    CUSHION_REG_W_EN   = 1'b0;
    CUSHION_REG_W_RD   = '0;
    CUSHION_REG_W_DATA = '0;
    CUSHION_CSR_W_EN   = 1'b0;
    CUSHION_CSR_W_ADDR = '0;
    CUSHION_CSR_W_DATA = '0;
    CUSHION_SIDE       = '0;
    if (!empty) begin
      CUSHION_VALID      = 1'b1;
      CUSHION_REG_W_EN   = q_reg_en[head];
      CUSHION_REG_W_RD   = q_reg_rd[head];
      CUSHION_REG_W_DATA = q_reg_data[head];
      CUSHION_CSR_W_EN   = q_csr_en[head];
      CUSHION_CSR_W_ADDR = q_csr_addr[head];
      CUSHION_CSR_W_DATA = q_csr_data[head];
      CUSHION_SIDE       = q_side[head];
    end
`ifdef CUSHION_QUEUE_BYPASS_EN
    else if (EXEC_VALID) begin
      CUSHION_VALID      = 1'b1;
      CUSHION_REG_W_EN   = EXEC_REG_W_EN;
      CUSHION_REG_W_RD   = EXEC_REG_W_RD;
      CUSHION_REG_W_DATA = EXEC_REG_W_DATA;
      CUSHION_CSR_W_EN   = EXEC_CSR_W_EN;
      CUSHION_CSR_W_ADDR = EXEC_CSR_W_ADDR;
      CUSHION_CSR_W_DATA = EXEC_CSR_W_DATA;
      CUSHION_SIDE       = EXEC_SIDE;
    end
`endif
  end

  assign push = EXEC_VALID & EXEC_READY & ~FLUSH;
  assign pop  = CUSHION_VALID & CUSHION_READY & ~MEM_WAIT & ~FLUSH;

`ifdef CUSHION_QUEUE_BYPASS_EN
  // A bypassed entry consumed in its own cycle never occupies a slot.
  assign wr  = push & ~(empty & pop);
  assign adv = pop & ~empty;
`else
  assign wr  = push;
  assign adv = pop;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (FLUSH) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr)  tail <= tail + 1'b1;
      if (adv) head <= head + 1'b1;
      case ({wr, adv})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge CLK) begin
    if (wr) begin
      q_reg_en[tail]   <= EXEC_REG_W_EN;
      q_reg_rd[tail]   <= EXEC_REG_W_RD;
      q_reg_data[tail] <= EXEC_REG_W_DATA;
      q_csr_en[tail]   <= EXEC_CSR_W_EN;
      q_csr_addr[tail] <= EXEC_CSR_W_ADDR;
      q_csr_data[tail] <= EXEC_CSR_W_DATA;
      q_side[tail]     <= EXEC_SIDE;
    end
  end

  // Walk from the head (oldest) towards the tail; later matches overwrite
  // earlier ones, so the youngest matching entry wins.
  always_comb begin
    FWD_REG_HIT  = 1'b0;
    FWD_REG_DATA = '0;
    FWD_CSR_HIT  = 1'b0;
    FWD_CSR_DATA = '0;
    fwd_idx      = head;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = head + AW'(i);
      if (CW'(i) < count) begin
        if (q_reg_en[fwd_idx] && (q_reg_rd[fwd_idx] == FWD_REG_ADDR) &&
            (FWD_REG_ADDR != 5'd0)) begin
          FWD_REG_HIT  = 1'b1;
          FWD_REG_DATA = q_reg_data[fwd_idx];
        end
        if (q_csr_en[fwd_idx] && (q_csr_addr[fwd_idx] == FWD_CSR_ADDR)) begin
          FWD_CSR_HIT  = 1'b1;
          FWD_CSR_DATA = q_csr_data[fwd_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_cushion_queue.sv
// tb_cushion_queue
//   Directed bench for cushion_queue (DEPTH=4, SIDE_W=182). Accepted pushes
//   are recorded in a scoreboard queue; each cycle the head, occupancy,
//   ready/valid and both forwarding ports are compared against it.
module tb_cushion_queue;

  localparam int DEPTH  = 4;
  localparam int SIDE_W = 182;

  typedef struct packed {
    logic              reg_en;
    logic [4:0]        rd;
    logic [31:0]       rdata;
    logic              csr_en;
    logic [11:0]       caddr;
    logic [31:0]       cdata;
    logic [SIDE_W-1:0] side;
  } entry_t;

  logic CLK = 1'b0;
  logic RST, FLUSH, MEM_WAIT, EXEC_VALID, EXEC_READY, CUSHION_VALID, CUSHION_READY;
  logic EXEC_REG_W_EN, EXEC_CSR_W_EN, CUSHION_REG_W_EN, CUSHION_CSR_W_EN;
  logic [4:0]  EXEC_REG_W_RD, CUSHION_REG_W_RD, FWD_REG_ADDR;
  logic [31:0] EXEC_REG_W_DATA, EXEC_CSR_W_DATA, CUSHION_REG_W_DATA, CUSHION_CSR_W_DATA;
  logic [11:0] EXEC_CSR_W_ADDR, CUSHION_CSR_W_ADDR, FWD_CSR_ADDR;
  logic [SIDE_W-1:0] EXEC_SIDE, CUSHION_SIDE;
  logic        FWD_REG_HIT, FWD_CSR_HIT;
  logic [31:0] FWD_REG_DATA, FWD_CSR_DATA;
  logic [$clog2(DEPTH):0] COUNT;

  int checks = 0;
  int passed = 0;
  int tag = 0;
  entry_t sb[$];

  always #5 CLK = ~CLK;

  cushion_queue #(.DEPTH(DEPTH), .SIDE_W(SIDE_W)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .MEM_WAIT(MEM_WAIT),
    .EXEC_VALID(EXEC_VALID), .EXEC_READY(EXEC_READY),
    .EXEC_REG_W_EN(EXEC_REG_W_EN), .EXEC_REG_W_RD(EXEC_REG_W_RD),
    .EXEC_REG_W_DATA(EXEC_REG_W_DATA), .EXEC_CSR_W_EN(EXEC_CSR_W_EN),
    .EXEC_CSR_W_ADDR(EXEC_CSR_W_ADDR), .EXEC_CSR_W_DATA(EXEC_CSR_W_DATA),
    .EXEC_SIDE(EXEC_SIDE), .CUSHION_VALID(CUSHION_VALID),
    .CUSHION_READY(CUSHION_READY), .CUSHION_REG_W_EN(CUSHION_REG_W_EN),
    .CUSHION_REG_W_RD(CUSHION_REG_W_RD), .CUSHION_REG_W_DATA(CUSHION_REG_W_DATA),
    .CUSHION_CSR_W_EN(CUSHION_CSR_W_EN), .CUSHION_CSR_W_ADDR(CUSHION_CSR_W_ADDR),
    .CUSHION_CSR_W_DATA(CUSHION_CSR_W_DATA), .CUSHION_SIDE(CUSHION_SIDE),
    .FWD_REG_ADDR(FWD_REG_ADDR), .FWD_REG_HIT(FWD_REG_HIT),
    .FWD_REG_DATA(FWD_REG_DATA), .FWD_CSR_ADDR(FWD_CSR_ADDR),
    .FWD_CSR_HIT(FWD_CSR_HIT), .FWD_CSR_DATA(FWD_CSR_DATA), .COUNT(COUNT)
  );

  task automatic check(input string name, input logic [271:0] obs, input logic [271:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  task automatic drive(input logic ren, input logic [4:0] rd, input logic [31:0] rdata,
                       input logic cen, input logic [11:0] caddr, input logic [31:0] cdata);
    logic [191:0] wide;
    tag++;
    wide = {6{32'(tag) ^ 32'hA5A5_0000}};
    EXEC_VALID = 1'b1;
    EXEC_REG_W_EN = ren;  EXEC_REG_W_RD = rd;     EXEC_REG_W_DATA = rdata;
    EXEC_CSR_W_EN = cen;  EXEC_CSR_W_ADDR = caddr; EXEC_CSR_W_DATA = cdata;
    EXEC_SIDE = wide[SIDE_W-1:0];
  endtask

  task automatic idle();
    EXEC_VALID = 1'b0;
  endtask

  // Compare everything against the scoreboard, then advance one clock.
  task automatic cycle();
    logic exp_valid, rhit, chit, push_acc, pop_acc;
    logic [31:0] rdat, cdat;
    entry_t obs, ex;
    #2;
    exp_valid = (sb.size() != 0);
`ifdef CUSHION_QUEUE_BYPASS_EN
    exp_valid = exp_valid || EXEC_VALID;
`endif
    check("count", 272'(COUNT), 272'(sb.size()));
    check("exec_ready", 272'(EXEC_READY), 272'(sb.size() != DEPTH));
    check("cushion_valid", 272'(CUSHION_VALID), 272'(exp_valid));
    rhit = 0; rdat = 0; chit = 0; cdat = 0;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].reg_en && sb[i].rd == FWD_REG_ADDR && FWD_REG_ADDR != 0) begin
        rhit = 1; rdat = sb[i].rdata;
      end
      if (sb[i].csr_en && sb[i].caddr == FWD_CSR_ADDR) begin
        chit = 1; cdat = sb[i].cdata;
      end
    end
    check("fwd_reg", 272'({FWD_REG_HIT, FWD_REG_DATA}), 272'({rhit, rdat}));
    check("fwd_csr", 272'({FWD_CSR_HIT, FWD_CSR_DATA}), 272'({chit, cdat}));
    push_acc = EXEC_VALID && (sb.size() != DEPTH) && !FLUSH;
    pop_acc  = exp_valid && CUSHION_READY && !MEM_WAIT && !FLUSH;
    if (push_acc)
      sb.push_back({EXEC_REG_W_EN, EXEC_REG_W_RD, EXEC_REG_W_DATA, EXEC_CSR_W_EN,
                    EXEC_CSR_W_ADDR, EXEC_CSR_W_DATA, EXEC_SIDE});
    obs = {CUSHION_REG_W_EN, CUSHION_REG_W_RD, CUSHION_REG_W_DATA, CUSHION_CSR_W_EN,
           CUSHION_CSR_W_ADDR, CUSHION_CSR_W_DATA, CUSHION_SIDE};
    ex = exp_valid ? sb[0] : '0;
    check("head", 272'(obs), 272'(ex));
    if (pop_acc) void'(sb.pop_front());
    if (FLUSH) sb.delete();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    idle();
    CUSHION_READY = 1'b1; MEM_WAIT = 1'b0;
    for (int n = 0; n < 2 * DEPTH && sb.size() != 0; n++) cycle();
    check("drained", 272'(COUNT), 272'(0));
  endtask

  initial begin
    RST = 1'b0; FLUSH = 1'b0; MEM_WAIT = 1'b0; CUSHION_READY = 1'b0;
    EXEC_VALID = 1'b0; EXEC_REG_W_EN = 1'b0; EXEC_REG_W_RD = '0; EXEC_REG_W_DATA = '0;
    EXEC_CSR_W_EN = 1'b0; EXEC_CSR_W_ADDR = '0; EXEC_CSR_W_DATA = '0; EXEC_SIDE = '0;
    FWD_REG_ADDR = 5'd5; FWD_CSR_ADDR = 12'h300;

    // Reset values
    #3;
    check("rst_count", 272'(COUNT), 272'(0));
    check("rst_ready", 272'(EXEC_READY), 272'(1));
    check("rst_valid", 272'(CUSHION_VALID), 272'(0));
    check("rst_head_data", 272'(CUSHION_REG_W_DATA), 272'(0));
    check("rst_fwd", 272'({FWD_REG_HIT, FWD_REG_DATA, FWD_CSR_HIT, FWD_CSR_DATA}), 272'(0));
    @(posedge CLK); #1;
    RST = 1'b1;

    // Single push, one-cycle latency, popped on the following edge
    CUSHION_READY = 1'b1;
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 12'h0, 32'h0);
    #1;
`ifdef CUSHION_QUEUE_BYPASS_EN
    check("t1_bypass_valid", 272'(CUSHION_VALID), 272'(1));
    CUSHION_READY = 1'b0;
`else
    check("t1_pre_valid", 272'(CUSHION_VALID), 272'(0));
`endif
    cycle();
    idle();
    CUSHION_READY = 1'b1;
    #1;
    check("t1_valid", 272'(CUSHION_VALID), 272'(1));
    check("t1_data", 272'(CUSHION_REG_W_DATA), 272'(32'h1234));
    check("t1_fwd5", 272'({FWD_REG_HIT, FWD_REG_DATA}), 272'({1'b1, 32'h1234}));
    cycle();
    check("t1_count0", 272'(COUNT), 272'(0));

    // MEM_WAIT holds the head; fill to DEPTH, the extra push is ignored
    MEM_WAIT = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(1'b1, 5'(i + 10), 32'h100 + 32'(i), 1'b0, 12'h0, 32'h0);
      cycle();
    end
    idle();
    #1;
    check("t2_full_count", 272'(COUNT), 272'(DEPTH));
    check("t2_not_ready", 272'(EXEC_READY), 272'(0));
    check("t2_head", 272'(CUSHION_REG_W_DATA), 272'(32'h100));
    MEM_WAIT = 1'b0;
    for (int i = 0; i < DEPTH; i++) cycle();
    check("t2_empty", 272'(COUNT), 272'(0));

    // GPR forwarding, youngest wins; x0 never hits
    CUSHION_READY = 1'b0;
    FWD_REG_ADDR = 5'd7;
    drive(1'b1, 5'd7, 32'h11, 1'b0, 12'h0, 32'h0); cycle();
    drive(1'b1, 5'd7, 32'h22, 1'b0, 12'h0, 32'h0); cycle();
    drive(1'b1, 5'd0, 32'h99, 1'b0, 12'h0, 32'h0); cycle();
    idle();
    #1;
    check("t3_fwd7", 272'({FWD_REG_HIT, FWD_REG_DATA}), 272'({1'b1, 32'h22}));
    FWD_REG_ADDR = 5'd0;
    #1;
    check("t3_fwd0", 272'({FWD_REG_HIT, FWD_REG_DATA}), 272'(0));
    cycle();

    // CSR forwarding
    drive(1'b0, 5'd0, 32'h0, 1'b1, 12'h300, 32'h8); cycle();
    idle();
    FWD_CSR_ADDR = 12'h300;
    #1;
    check("t4_csr300", 272'({FWD_CSR_HIT, FWD_CSR_DATA}), 272'({1'b1, 32'h8}));
    FWD_CSR_ADDR = 12'h305;
    #1;
    check("t4_csr305", 272'({FWD_CSR_HIT, FWD_CSR_DATA}), 272'(0));
    cycle();

    // Pop one to leave 3, then FLUSH with a concurrent push
    CUSHION_READY = 1'b1; cycle();
    CUSHION_READY = 1'b0;
    FLUSH = 1'b1; FWD_REG_ADDR = 5'd7;
    drive(1'b1, 5'd9, 32'hDEAD, 1'b0, 12'h0, 32'h0);
    #1;
    check("t5_cnt3", 272'(COUNT), 272'(3));
    check("t5_fwd_unmasked", 272'({FWD_REG_HIT, FWD_REG_DATA}), 272'({1'b1, 32'h22}));
    cycle();
    FLUSH = 1'b0; idle();
    #1;
    check("t5_count", 272'(COUNT), 272'(0));
    check("t5_valid", 272'(CUSHION_VALID), 272'(0));
    cycle();

    // Sustained push+pop across the pointer wrap
    drive(1'b1, 5'd1, 32'hA0, 1'b0, 12'h0, 32'h0); cycle();
    drive(1'b1, 5'd2, 32'hA1, 1'b0, 12'h0, 32'h0); cycle();
    CUSHION_READY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'(i + 3), 32'hB0 + 32'(i), 1'b1, 12'(i), 32'hC0 + 32'(i));
      FWD_REG_ADDR = 5'(i + 2);
      #1;
      check("t6_count", 272'(COUNT), 272'(2));
      cycle();
    end
    drain();

    // Asynchronous reset mid-operation
    CUSHION_READY = 1'b0;
    drive(1'b1, 5'd3, 32'h33, 1'b0, 12'h0, 32'h0); cycle();
    drive(1'b1, 5'd4, 32'h44, 1'b0, 12'h0, 32'h0); cycle();
    idle();
    RST = 1'b0;
    #1;
    check("t7_count", 272'(COUNT), 272'(0));
    check("t7_valid", 272'(CUSHION_VALID), 272'(0));
    check("t7_ready", 272'(EXEC_READY), 272'(1));
    sb.delete();
    RST = 1'b1;
    cycle();

    // Empty-queue push with the consumer ready
    CUSHION_READY = 1'b1;
    drive(1'b1, 5'd6, 32'h6666, 1'b0, 12'h0, 32'h0);
    #1;
`ifdef CUSHION_QUEUE_BYPASS_EN
    check("t8_same_cycle", 272'({CUSHION_VALID, CUSHION_REG_W_DATA}), 272'({1'b1, 32'h6666}));
    check("t8_no_fwd", 272'(FWD_REG_HIT), 272'(0));
    cycle();
    idle();
    #1;
    check("t8_never_stored", 272'(COUNT), 272'(0));
`else
    check("t8_not_yet", 272'(CUSHION_VALID), 272'(0));
    cycle();
    idle();
    #1;
    check("t8_next_cycle", 272'({CUSHION_VALID, CUSHION_REG_W_DATA}), 272'({1'b1, 32'h6666}));
`endif
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
